// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: redirect kinds, reset/exception
// PC defaults and the PC sequencer state encoding.
package mips_pkg;

  localparam logic [1:0] KIND_J   = 2'b00;
  localparam logic [1:0] KIND_BR  = 2'b01;
  localparam logic [1:0] KIND_JR  = 2'b10;
  localparam logic [1:0] KIND_RSV = 2'b11;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_JR_WAIT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target for J/JAL, conditional branch and JR.
// Reserved kinds return pcid_i; the sequencer never uses that value.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] pcid_i,
  input  logic [25:0] instr_id_i,
  input  logic [31:0] jr_tgt_i,
  input  logic [1:0]  kind_i,
  output logic [31:0] target_o
);

  logic [31:0] w_br_off;

  assign w_br_off = {{14{instr_id_i[15]}}, instr_id_i[15:0], 2'b00};

  always_comb begin
    case (kind_i)
      KIND_J:  target_o = {pcid_i[31:28], instr_id_i, 2'b00};
      KIND_BR: target_o = pcid_i + w_br_off;
      KIND_JR: target_o = jr_tgt_i;
      default: target_o = pcid_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential/redirect PC selection, JR operand wait FSM, fetch counter.
// Optional exception entry enabled by defining PC_EXC_EN.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redir_v_i,
  input  logic [1:0]       redir_kind_i,
  input  logic [31:0]      pcid_i,
  input  logic [25:0]      instr_id_i,
  input  logic [31:0]      jr_tgt_i,
  input  logic             jr_rdy_i,
  input  logic             exc_req_i,
  output logic [31:0]      pc_o,
  output logic             fetch_v_o,
  output logic             stall_req_o,
  output logic [31:0]      epc_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  pc_state_e        r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_target;
  logic             w_fetch_v;

  pc_target_calc u_target (
    .pcid_i     (pcid_i),
    .instr_id_i (instr_id_i),
    .jr_tgt_i   (jr_tgt_i),
    .kind_i     (redir_kind_i),
    .target_o   (w_target)
  );

  // Gated by reset so no fetch is reported while the pipeline is held in reset.
  assign w_fetch_v = reset && (r_state == ST_RUN) && !stall_i;

`ifdef PC_EXC_EN
  logic [31:0] r_epc, w_epc_nxt;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
`ifdef PC_EXC_EN
    w_epc_nxt   = r_epc;
`endif
    case (r_state)
      ST_RUN: begin
        if (stall_i) begin
          w_pc_nxt = r_pc;
        end else if (redir_v_i && redir_kind_i != KIND_RSV) begin
          if (redir_kind_i == KIND_JR && !jr_rdy_i) w_state_nxt = ST_JR_WAIT;
          else                                       w_pc_nxt    = w_target;
        end else begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_JR_WAIT: begin
        if (jr_rdy_i) begin
          w_pc_nxt    = jr_tgt_i;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
`ifdef PC_EXC_EN
    if (exc_req_i) begin
      w_epc_nxt   = r_pc;
      w_pc_nxt    = EXC_VECTOR;
      w_state_nxt = ST_RUN;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_fetch_v) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_epc <= '0;
    else        r_epc <= w_epc_nxt;
  end

  assign epc_o = r_epc;
`else
  logic w_unused;
  assign w_unused = ^{exc_req_i, EXC_VECTOR};
  assign epc_o    = '0;
`endif

  assign pc_o        = r_pc;
  assign fetch_v_o   = w_fetch_v;
  assign stall_req_o = (r_state == ST_JR_WAIT);
  assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus hand-written JR wrap,
// async reset in JR wait and (with PC_EXC_EN) exception entry sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redir_v_i, jr_rdy_i, exc_req_i;
  logic [1:0]  redir_kind_i;
  logic [31:0] pcid_i, jr_tgt_i;
  logic [25:0] instr_id_i;
  logic [31:0] pc_o, epc_o, fetch_cnt_o;
  logic        fetch_v_o, stall_req_o;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .redir_v_i    (redir_v_i),
    .redir_kind_i (redir_kind_i),
    .pcid_i       (pcid_i),
    .instr_id_i   (instr_id_i),
    .jr_tgt_i     (jr_tgt_i),
    .jr_rdy_i     (jr_rdy_i),
    .exc_req_i    (exc_req_i),
    .pc_o         (pc_o),
    .fetch_v_o    (fetch_v_o),
    .stall_req_o  (stall_req_o),
    .epc_o        (epc_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [1:0]  kind;
    logic [31:0] pcid;
    logic [25:0] instr;
    logic [31:0] jrt;
    logic        jrr;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_sr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [1:0] k, input logic [31:0] pcid,
                       input logic [25:0] ins, input logic [31:0] jrt, input logic jrr);
    stall_i      = st;
    redir_v_i    = rv;
    redir_kind_i = k;
    pcid_i       = pcid;
    instr_id_i   = ins;
    jr_tgt_i     = jrt;
    jr_rdy_i     = jrr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    exc_req_i = 1'b0;
    #3;
    next_cycle();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic st, input logic rv, input logic [1:0] k, input logic [31:0] pcid,
                              input logic [25:0] ins, input logic [31:0] jrt, input logic jrr,
                              input logic [31:0] epc, input logic efv, input logic esr, input logic [31:0] ecnt);
    vec_t v;
    v.stall = st; v.redir = rv; v.kind = k; v.pcid = pcid; v.instr = ins;
    v.jrt = jrt; v.jrr = jrr; v.exp_pc = epc; v.exp_fv = efv; v.exp_sr = esr; v.exp_cnt = ecnt;
    return v;
  endfunction

  initial begin
    // Each row: inputs for this cycle and the outputs expected in the same cycle.
    vecs[0]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3004, 1, 0, 1);
    vecs[2]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3008, 1, 0, 2);
    vecs[3]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h300C, 1, 0, 3);
    vecs[4]  = mk(0, 1, 2'b00, 32'h3010, 26'h0000C10, 32'h0,   0, 32'h3010, 1, 0, 4);
    vecs[5]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3040, 1, 0, 5);
    vecs[6]  = mk(0, 1, 2'b01, 32'h3020, 26'h000FFFC, 32'h0,   0, 32'h3044, 1, 0, 6);
    vecs[7]  = mk(0, 1, 2'b01, 32'h3020, 26'h0000004, 32'h0,   0, 32'h3010, 1, 0, 7);
    vecs[8]  = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3030, 1, 0, 8);
    vecs[9]  = mk(0, 1, 2'b11, 32'h5000, 26'h0001234, 32'h7000, 1, 32'h3034, 1, 0, 9);
    vecs[10] = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3038, 1, 0, 10);
    vecs[11] = mk(1, 1, 2'b00, 32'h3040, 26'h0000D00, 32'h0,   0, 32'h303C, 0, 0, 11);
    vecs[12] = mk(1, 1, 2'b00, 32'h3040, 26'h0000D00, 32'h0,   0, 32'h303C, 0, 0, 11);
    vecs[13] = mk(0, 1, 2'b00, 32'h3040, 26'h0000D00, 32'h0,   0, 32'h303C, 1, 0, 11);
    vecs[14] = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3400, 1, 0, 12);
    vecs[15] = mk(0, 1, 2'b10, 32'h3408, 26'h0,      32'hDEAD, 0, 32'h3404, 1, 0, 13);
    vecs[16] = mk(0, 1, 2'b10, 32'h3408, 26'h0,      32'hDEAD, 0, 32'h3404, 0, 1, 14);
    vecs[17] = mk(1, 1, 2'b10, 32'h3408, 26'h0,      32'hBEEF, 0, 32'h3404, 0, 1, 14);
    vecs[18] = mk(1, 1, 2'b10, 32'h3408, 26'h0,      32'h3100, 1, 32'h3404, 0, 1, 14);
    vecs[19] = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3100, 1, 0, 14);
    vecs[20] = mk(0, 1, 2'b10, 32'h3108, 26'h0,      32'h3203, 1, 32'h3104, 1, 0, 15);
    vecs[21] = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3203, 1, 0, 16);
    vecs[22] = mk(0, 0, 2'b00, 32'h0,    26'h0,      32'h0,    0, 32'h3207, 1, 0, 17);

    reset = 1'b0;
    exc_req_i = 1'b0;
    idle();
    #12;
    check("reset_pc", pc_o, 32'h3000);
    check("reset_fetch_v", {31'b0, fetch_v_o}, 32'h0);
    check("reset_stall_req", {31'b0, stall_req_o}, 32'h0);
    check("reset_epc", epc_o, 32'h0);
    check("reset_cnt", fetch_cnt_o, 32'h0);
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].kind, vecs[i].pcid, vecs[i].instr,
            vecs[i].jrt, vecs[i].jrr);
      @(negedge clk);
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      check($sformatf("v%0d_fetch_v", i), {31'b0, fetch_v_o}, {31'b0, vecs[i].exp_fv});
      check($sformatf("v%0d_stall_req", i), {31'b0, stall_req_o}, {31'b0, vecs[i].exp_sr});
      check($sformatf("v%0d_cnt", i), fetch_cnt_o, vecs[i].exp_cnt);
      next_cycle();
    end

    // PC wrap: JR to the last word, then sequential fetch wraps to zero.
    drive(1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("wrap_top", pc_o, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check("wrap_zero", pc_o, 32'h0000_0000);
    check("default_epc", epc_o, 32'h0);

    // Async reset while waiting on a JR operand takes effect without a clock edge.
    drive(1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check("jrwait_entered", {31'b0, stall_req_o}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", pc_o, 32'h3000);
    check("async_rst_stall_req", {31'b0, stall_req_o}, 32'h0);
    check("async_rst_cnt", fetch_cnt_o, 32'h0);
    check("async_rst_fetch_v", {31'b0, fetch_v_o}, 32'h0);
    idle();
    next_cycle();
    reset = 1'b1;

`ifdef PC_EXC_EN
    // Exception taken out of JR wait at pc 3050.
    drive(1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h3050, 1'b1);
    next_cycle();
    drive(1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check("exc_wait_pc", pc_o, 32'h3050);
    check("exc_wait_sr", {31'b0, stall_req_o}, 32'h1);
    exc_req_i = 1'b1;
    next_cycle();
    exc_req_i = 1'b0;
    idle();
    @(negedge clk);
    check("exc_pc", pc_o, 32'h4180);
    check("exc_epc", epc_o, 32'h3050);
    check("exc_state_run", {31'b0, stall_req_o}, 32'h0);
    check("exc_fetch_v", {31'b0, fetch_v_o}, 32'h1);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
